// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: byte-in, ALU-drive and result handshake bundle for the sequencer.
interface alu_op_sequencer_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [2:0] alu_ctrl;
  logic [1:0] shamt;
  logic [7:0] alu_result;
  logic       alu_cout;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [2:0] res_flags;
  logic       busy;
  modport master (
    output din, din_valid, alu_result, alu_cout, res_ready,
    input  din_ready, op_a, op_b, alu_ctrl, shamt, res_valid, res_data, res_flags, busy
  );
  modport slave (
    input  din, din_valid, alu_result, alu_cout, res_ready,
    output din_ready, op_a, op_b, alu_ctrl, shamt, res_valid, res_data, res_flags, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: loads A, B, command over a byte bus, holds them on the ALU for
// EXEC_CYCLES, then offers the captured result and {N,C,Z} on a valid/ready handshake.
module alu_op_sequencer #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  input logic clear,
  alu_op_sequencer_if.slave bus
);
  typedef enum logic [2:0] {LOAD_A, LOAD_B, LOAD_CMD, EXEC, RESULT} state_e;
  state_e     state_q;
  logic [7:0] op_a_q, op_b_q, res_data_q;
  logic [2:0] alu_ctrl_q, res_flags_q;
  logic [1:0] shamt_q;
  logic [3:0] cnt_q;
  logic       din_fire;
  logic       unused_cmd_hi;
  assign bus.din_ready = state_q inside {LOAD_A, LOAD_B, LOAD_CMD};
  assign bus.res_valid = state_q == RESULT;
  assign bus.busy      = state_q != LOAD_A;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.shamt     = shamt_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_flags = res_flags_q;
  assign din_fire      = bus.din_valid && bus.din_ready;
  assign unused_cmd_hi = ^bus.din[7:5];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD_A;
      op_a_q      <= 8'h00;
      op_b_q      <= 8'h00;
      alu_ctrl_q  <= 3'b000;
      shamt_q     <= 2'b00;
      res_data_q  <= 8'h00;
      res_flags_q <= 3'b000;
      cnt_q       <= 4'd0;
    end else if (clear) begin
      state_q <= LOAD_A;
    end else begin
      case (state_q)
        LOAD_A: if (din_fire) begin
          op_a_q  <= bus.din;
          state_q <= LOAD_B;
        end
        LOAD_B: if (din_fire) begin
          op_b_q  <= bus.din;
          state_q <= LOAD_CMD;
        end
        LOAD_CMD: if (din_fire) begin
          alu_ctrl_q <= bus.din[2:0];
          shamt_q    <= bus.din[4:3];
          cnt_q      <= 4'(EXEC_CYCLES - 1);
          state_q    <= EXEC;
        end
        // the counter reaching zero marks the last settle cycle; sample on that edge
        EXEC: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        else begin
          res_data_q  <= bus.alu_result;
          res_flags_q <= {bus.alu_result[7], bus.alu_cout, bus.alu_result == 8'h00};
          state_q     <= RESULT;
        end
        RESULT: if (bus.res_ready) state_q <= LOAD_A;
        default: state_q <= LOAD_A;
      endcase
    end
  end
endmodule
